// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS widths, HALT constant and opcode/funct encodings
package mips_pkg;

  localparam int NB_INST = 32;
  localparam int NB_ADDR = 32;

  localparam logic [NB_INST-1:0] HALT = '0;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct field (instr[5:0])
  localparam logic [5:0] FUNCT_SLL  = 6'h00;
  localparam logic [5:0] FUNCT_JR   = 6'h08;
  localparam logic [5:0] FUNCT_JALR = 6'h09;
  localparam logic [5:0] FUNCT_ADDU = 6'h21;
  localparam logic [5:0] FUNCT_SUBU = 6'h23;
  localparam logic [5:0] FUNCT_AND  = 6'h24;
  localparam logic [5:0] FUNCT_OR   = 6'h25;

endpackage

// File: rtl/imem_ram.sv
// rtl/imem_ram.sv - N_WORDS x NB_INST array: sync write, async read, sync clear
module imem_ram #(
  parameter int NB_INST = 32,
  parameter int N_WORDS = 256,
  parameter int AW      = $clog2(N_WORDS)
) (
  input  logic               clk,
  input  logic               clear,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [NB_INST-1:0] wdata,
  input  logic [AW-1:0]      raddr,
  output logic [NB_INST-1:0] rdata
);

  logic [NB_INST-1:0] mem [N_WORDS];

  // Clear has priority so a loader caught mid-transfer leaves an all-HALT image.
  always_ff @(posedge clk) begin
    if (clear) begin
      for (int i = 0; i < N_WORDS; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/if_memoria_instrucciones.sv
// rtl/if_memoria_instrucciones.sv - IF-stage instruction memory with range checks
// Optional same-cycle write-to-read bypass enabled by defining IMEM_WRITE_BYPASS_EN.
module if_memoria_instrucciones
  import mips_pkg::*;
#(
  parameter int NB_INST = mips_pkg::NB_INST,
  parameter int NB_ADDR = mips_pkg::NB_ADDR,
  parameter int N_WORDS = 256
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NB_ADDR-1:0] i_pc,
  input  logic               i_write,
  input  logic [NB_INST-1:0] i_instruction,
  input  logic [NB_ADDR-1:0] i_address,
  output logic [NB_INST-1:0] o_instruction
);

  localparam int AW = $clog2(N_WORDS);

  logic               pc_in_range;
  logic               addr_in_range;
  logic [NB_INST-1:0] ram_data;

  // Word indices: any set bit above the index field means out of range.
  assign pc_in_range   = ((i_pc >> AW) == '0);
  assign addr_in_range = ((i_address >> AW) == '0);

  imem_ram #(
    .NB_INST (NB_INST),
    .N_WORDS (N_WORDS),
    .AW      (AW)
  ) u_ram (
    .clk   (i_clk),
    .clear (i_reset),
    .we    (i_write && addr_in_range),
    .waddr (i_address[AW-1:0]),
    .wdata (i_instruction),
    .raddr (i_pc[AW-1:0]),
    .rdata (ram_data)
  );

`ifdef IMEM_WRITE_BYPASS_EN
  logic bypass_hit;

  assign bypass_hit = i_write && !i_reset && addr_in_range && (i_pc == i_address);

  always_comb begin
    o_instruction = HALT;
    if (bypass_hit) begin
      o_instruction = i_instruction;
    end else if (pc_in_range) begin
      o_instruction = ram_data;
    end
  end
`else
  always_comb begin
    o_instruction = HALT;
    if (pc_in_range) begin
      o_instruction = ram_data;
    end
  end
`endif

endmodule

// File: tb/tb_if_memoria_instrucciones.sv
// tb/tb_if_memoria_instrucciones.sv - directed self-checking bench for if_memoria_instrucciones
module tb_if_memoria_instrucciones;

  localparam int NB_INST = 32;
  localparam int NB_ADDR = 32;
  localparam int N_WORDS = 256;

  localparam logic [31:0] ADDU_W = 32'h00223021;
  localparam logic [31:0] LW_W   = 32'h8C400038;
  localparam logic [31:0] J_W    = 32'h08000001;
  localparam logic [31:0] SW_W   = 32'hAC400038;

  logic               clk = 1'b0;
  logic               reset;
  logic [NB_ADDR-1:0] pc;
  logic               write;
  logic [NB_INST-1:0] instruction;
  logic [NB_ADDR-1:0] address;
  logic [NB_INST-1:0] rd;

  int errors = 0;
  int checks = 0;

  if_memoria_instrucciones #(
    .NB_INST (NB_INST),
    .NB_ADDR (NB_ADDR),
    .N_WORDS (N_WORDS)
  ) dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_pc          (pc),
    .i_write       (write),
    .i_instruction (instruction),
    .i_address     (address),
    .o_instruction (rd)
  );

  always #5 clk = ~clk;

  task automatic write_word(input logic [NB_ADDR-1:0] a, input logic [NB_INST-1:0] d);
    @(negedge clk);
    write       = 1'b1;
    address     = a;
    instruction = d;
    @(posedge clk);
    #1;
    write = 1'b0;
  endtask

  task automatic test_reset;
    logic [NB_ADDR-1:0] pcs [3];
    pcs[0] = 0;
    pcs[1] = 1;
    pcs[2] = N_WORDS - 1;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pc = pcs[i];
      #1;
      checks++;
      if (rd !== 32'h0) begin
        errors++;
        $display("FAIL reset_read pc=%0d: got %h expected %h", pc, rd, 32'h0);
      end
    end
  endtask

  task automatic test_write_read;
    write_word(1, ADDU_W);
    pc = 1;
    #1;
    checks++;
    if (rd !== ADDU_W) begin
      errors++;
      $display("FAIL addu_read pc=1: got %h expected %h", rd, ADDU_W);
    end
    pc = 0;
    #1;
    checks++;
    if (rd !== 32'h0) begin
      errors++;
      $display("FAIL untouched_read pc=0: got %h expected %h", rd, 32'h0);
    end
  endtask

  task automatic test_boundaries;
    write_word(0, LW_W);
    write_word(N_WORDS - 1, J_W);
    pc = 0;
    #1;
    checks++;
    if (rd !== LW_W) begin
      errors++;
      $display("FAIL lw_read pc=0: got %h expected %h", rd, LW_W);
    end
    pc = N_WORDS - 1;
    #1;
    checks++;
    if (rd !== J_W) begin
      errors++;
      $display("FAIL j_read pc=%0d: got %h expected %h", pc, rd, J_W);
    end
  endtask

  task automatic test_out_of_range;
    logic [NB_ADDR-1:0] a [4];
    logic [31:0]        e [4];
    write_word(N_WORDS, 32'hFFFFFFFF);
    write_word(32'h8000_0001, 32'hFFFFFFFF);
    a[0] = 0;           e[0] = LW_W;
    a[1] = 1;           e[1] = ADDU_W;
    a[2] = N_WORDS - 1; e[2] = J_W;
    a[3] = 2;           e[3] = 32'h0;
    for (int i = 0; i < 4; i++) begin
      pc = a[i];
      #1;
      checks++;
      if (rd !== e[i]) begin
        errors++;
        $display("FAIL oor_write_alias pc=%0d: got %h expected %h", pc, rd, e[i]);
      end
    end
    pc = N_WORDS;
    #1;
    checks++;
    if (rd !== 32'h0) begin
      errors++;
      $display("FAIL oor_read pc=%0d: got %h expected %h", pc, rd, 32'h0);
    end
    pc = 32'h8000_0001;
    #1;
    checks++;
    if (rd !== 32'h0) begin
      errors++;
      $display("FAIL oor_read_high pc=%h: got %h expected %h", pc, rd, 32'h0);
    end
  endtask

  task automatic test_reset_mid_load;
    logic [NB_ADDR-1:0] a [4];
    @(negedge clk);
    reset       = 1'b1;
    write       = 1'b1;
    address     = 2;
    instruction = 32'h1234_5678;
    @(posedge clk);
    #1;
    reset = 1'b0;
    write = 1'b0;
    a[0] = 0;
    a[1] = 1;
    a[2] = 2;
    a[3] = N_WORDS - 1;
    for (int i = 0; i < 4; i++) begin
      pc = a[i];
      #1;
      checks++;
      if (rd !== 32'h0) begin
        errors++;
        $display("FAIL reset_dominates pc=%0d: got %h expected %h", pc, rd, 32'h0);
      end
    end
  endtask

  task automatic test_same_cycle;
    logic [31:0] before_edge;
`ifdef IMEM_WRITE_BYPASS_EN
    before_edge = SW_W;
`else
    before_edge = 32'h0;
`endif
    @(negedge clk);
    pc          = 3;
    address     = 3;
    instruction = SW_W;
    write       = 1'b1;
    #1;
    checks++;
    if (rd !== before_edge) begin
      errors++;
      $display("FAIL same_cycle_before: got %h expected %h", rd, before_edge);
    end
    @(posedge clk);
    #1;
    write = 1'b0;
    #1;
    checks++;
    if (rd !== SW_W) begin
      errors++;
      $display("FAIL same_cycle_after: got %h expected %h", rd, SW_W);
    end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    write       = 1'b1;
    address     = 10;
    instruction = 32'hA0A0_0001;
    @(negedge clk);
    address     = 11;
    instruction = 32'hA0A0_0002;
    @(negedge clk);
    write = 1'b0;
    for (int i = 0; i < 2; i++) begin
      pc = 10 + i;
      #1;
      checks++;
      if (rd !== (32'hA0A0_0001 + i)) begin
        errors++;
        $display("FAIL back_to_back pc=%0d: got %h expected %h", pc, rd, 32'hA0A0_0001 + i);
      end
    end
  endtask

  initial begin
    reset       = 1'b0;
    pc          = '0;
    write       = 1'b0;
    instruction = '0;
    address     = '0;
    test_reset();
    test_write_read();
    test_boundaries();
    test_out_of_range();
    test_reset_mid_load();
    test_same_cycle();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
